// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo-MODULUS up/down counter.
// Each state bit is a JK flip-flop. During counting, each flop is driven in
// toggle mode (J = K = T).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (J=0, K=1 on every bit)
//   en        count enable
//   up_dn     direction, 1 = up, 0 = down
//   load      parallel load strobe (has priority over en)
//   load_val  value to load. Values >= MODULUS saturate to MODULUS-1.
//   count     current count, taken from the JK flop q outputs
//   tc        terminal count, combinational: the next edge will wrap
//   wrap      registered one-cycle pulse after a wrap edge
//   load_err  registered one-cycle pulse after an out-of-range load

// jk_ff: JK flip-flop built on a single D flop.
// Next state is q+ = (J & ~q) | (~K & q).
// Ports: clk clock, j/k excitation inputs, q state output.
module jk_ff (
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // MODULUS may equal 2^WIDTH, so one extra bit is needed for the range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] target;
  logic             load_ok;
  logic             wrap_d;
  logic             wrap_q;
  logic             load_err_d;
  logic             load_err_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_jk (
      .clk (clk),
      .j   (j_d[i]),
      .k   (k_d[i]),
      .q   (count[i])
    );
  end

  // The next count is first computed as a plain value (target).
  // For counting, the toggle mask is then count ^ target, so J = K = T.
  // For loading, J and K force each bit to the target level directly.
  always_comb begin
    j_d        = '0;
    k_d        = '0;
    target     = '0;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    load_ok    = ({1'b0, load_val} < MOD_EXT);

    if (rst) begin
      j_d = '0;
      k_d = '1;
    end else if (load) begin
      target     = load_ok ? load_val : MAX_CNT;
      load_err_d = ~load_ok;
      j_d        = target;
      k_d        = ~target;
    end else if (en) begin
      if (up_dn) begin
        // Counts above MAX_CNT are illegal. They recover to 0 without a wrap.
        target = (count >= MAX_CNT) ? '0 : count + 1'b1;
        wrap_d = (count == MAX_CNT);
      end else begin
        // Counts above MAX_CNT are illegal. They recover to MAX_CNT without a wrap.
        if (count == '0) begin
          target = MAX_CNT;
          wrap_d = 1'b1;
        end else if (count > MAX_CNT) begin
          target = MAX_CNT;
        end else begin
          target = count - 1'b1;
        end
      end
      j_d = count ^ target;
      k_d = count ^ target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = ~rst & en & ~load &
                    ((up_dn & (count == MAX_CNT)) | (~up_dn & (count == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] count0, count1;
  logic       tc0, tc1, wrap0, wrap1, lerr0, lerr1;

  int n_tests = 0;
  int n_fail  = 0;

  int mods [2] = '{10, 16};
  int mc   [2] = '{0, 0};
  int mw   [2] = '{0, 0};
  int ml   [2] = '{0, 0};

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count0), .tc(tc0), .wrap(wrap0), .load_err(lerr0)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count1), .tc(tc1), .wrap(wrap1), .load_err(lerr1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: the spec's rules written as modular arithmetic.
  function automatic int exp_tc(input int d);
    if (rst || !en || load) return 0;
    if (up_dn) return (mc[d] == mods[d] - 1) ? 1 : 0;
    return (mc[d] == 0) ? 1 : 0;
  endfunction

  task automatic cycle();
    int nc [2];
    int nw [2];
    int nl [2];
    @(negedge clk);
    check("tc_m10", int'(tc0), exp_tc(0));
    check("tc_m16", int'(tc1), exp_tc(1));
    for (int d = 0; d < 2; d++) begin
      nc[d] = mc[d];
      nw[d] = 0;
      nl[d] = 0;
      if (rst) begin
        nc[d] = 0;
      end else if (load) begin
        if (int'(load_val) < mods[d]) begin
          nc[d] = int'(load_val);
        end else begin
          nc[d] = mods[d] - 1;
          nl[d] = 1;
        end
      end else if (en) begin
        if (up_dn) begin
          nw[d] = (mc[d] == mods[d] - 1) ? 1 : 0;
          nc[d] = (mc[d] + 1) % mods[d];
        end else begin
          nw[d] = (mc[d] == 0) ? 1 : 0;
          nc[d] = (mc[d] + mods[d] - 1) % mods[d];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mc[d] = nc[d];
      mw[d] = nw[d];
      ml[d] = nl[d];
    end
    check("count_m10", int'(count0), mc[0]);
    check("wrap_m10",  int'(wrap0),  mw[0]);
    check("lerr_m10",  int'(lerr0),  ml[0]);
    check("count_m16", int'(count1), mc[1]);
    check("wrap_m16",  int'(wrap1),  mw[1]);
    check("lerr_m16",  int'(lerr1),  ml[1]);
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] v, input int n);
    rst = r; en = e; up_dn = u; load = l; load_val = v;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset, then count up through a wrap.
    drive(1, 0, 1, 0, 4'd0, 2);
    drive(0, 1, 1, 0, 4'd0, 12);
    // Count down from 0 with wrap.
    drive(1, 0, 1, 0, 4'd0, 1);
    drive(0, 1, 0, 0, 4'd0, 4);
    // Load priority and out-of-range load.
    drive(0, 1, 1, 1, 4'd5, 1);
    drive(0, 1, 1, 1, 4'd12, 1);
    drive(0, 0, 1, 0, 4'd0, 1);
    // Hold, then alternate direction.
    drive(0, 0, 1, 1, 4'd4, 1);
    drive(0, 0, 1, 0, 4'd0, 3);
    for (int i = 0; i < 4; i++) drive(0, 1, (i % 2 == 0), 0, 4'd0, 1);
    // Reset mid-operation overrides load and enable.
    drive(0, 0, 1, 1, 4'd7, 1);
    drive(1, 1, 1, 1, 4'd3, 1);
    // Count up from 14: the modulus-16 unit wraps 15 -> 0.
    drive(0, 0, 1, 1, 4'd14, 1);
    drive(0, 1, 1, 0, 4'd0, 3);
    // Randomized mix.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 75),
            1'($urandom), ($urandom_range(0, 99) < 10), 4'($urandom), 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are JK flip-flops driven in toggle mode (J=K=T per bit).
- Per-bit toggle excitation is derived from the current count, the direction and the control inputs.
- Sits directly downstream of the JK flip-flop primitive and consumes it as its storage element.
- Used as the team's general event/period counter, with a parallel load and a terminal-count output for cascading.

Parameters:
- WIDTH, 4, counter width in bits. Legal range is 2 to 16.
- MODULUS, 10, count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2^WIDTH. Elaboration fails outside this range.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, taken from the JK flop q outputs.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse after a wrap.
- load_err  output  1  registered one-cycle pulse after an out-of-range load.

Behaviour:
- Storage
  - WIDTH JK flip-flops, each built on a D flop, all clocked on the rising edge of clk.
  - Next state of each bit: q+ = (J & ~q) | (~K & q).
  - Every bit uses toggle drive J = K = T[i], except during load and reset (see below).
- Priority, evaluated at each rising edge: rst > load > en > hold.
- rst=1
  - count <= 0, wrap <= 0, load_err <= 0.
  - Implemented as J=0, K=1 on every bit.
  - rst asserted mid-count takes effect at the next edge; no partial state survives.
- load=1 (rst=0)
  - If load_val < MODULUS: count <= load_val.
  - Otherwise: count <= MODULUS-1 and load_err <= 1 for exactly one cycle.
  - Implemented as J = target bit, K = ~target bit.
  - en and up_dn are ignored in a load cycle. wrap <= 0.
- en=1, load=0, up_dn=1
  - count <= count+1, or 0 when count == MODULUS-1.
  - Applies to non-power-of-2 MODULUS: the toggle mask clears exactly the set bits of MODULUS-1.
- en=1, load=0, up_dn=0
  - count <= count-1, or MODULUS-1 when count == 0.
- Wrap detection
  - A wrap is an up step from MODULUS-1 to 0, or a down step from 0 to MODULUS-1.
  - wrap <= 1 in the cycle after the wrap edge, 0 otherwise.
- en=0, load=0: hold. All T=0. wrap <= 0, load_err <= 0.
- tc = ~rst & en & ~load & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)).
  - tc is high in the same cycle that the next edge will wrap.
  - This allows cascading: a higher stage's en is driven from a lower stage's tc.
- Illegal states
  - Counts >= MODULUS are unreachable from reset.
  - If one is present anyway (e.g. X-recovery), an up step goes to 0 and a down step goes to MODULUS-1.
  - Neither case asserts wrap.
- up_dn may change on any cycle. The direction in effect at the edge is the one sampled at that edge.
- Latency
  - count updates one cycle after the control inputs.
  - tc has zero latency from count.
  - wrap and load_err assert one cycle after the causing edge.
- Reset values: count=0, wrap=0, load_err=0, tc=0 while rst is high.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset then count up
  - Stimulus: rst for 2 cycles, then en=1, up_dn=1 for 12 cycles.
  - Required: count goes 0,1,...,9,0,1. tc is high only while count=9. wrap is high the cycle count=0 after 9.
- Count down with wrap
  - Stimulus: from count=0, en=1, up_dn=0.
  - Required: tc=1 immediately. Next count=9, wrap=1. Then 8, 7, ...
- Load priority and range
  - Stimulus: load=1, load_val=5, en=1 → count=5, no wrap. Then load_val=12 → count=9, load_err pulses for 1 cycle.
- Hold and direction change
  - Stimulus: en=0 for 3 cycles at count=4.
  - Required: count stays 4, tc=0.
  - Stimulus: en=1 with up_dn toggled every cycle → count goes 5,4,5,4.
- Reset mid-operation
  - Stimulus: rst=1 while count=7, en=1, load=1, load_val=3.
  - Required: next count=0, wrap=0, load_err=0, tc=0.
- Power-of-2 modulus (MODULUS=16)
  - Stimulus: count up from 14.
  - Required: 14, 15, 0 with wrap=1. tc is high at 15 only.
